seg7_to_bin: RTL and testbench

//  Inverse of the display path: accepts DIGITS seven-segment codes (digit-entry or display readback) and returns the binary value.

---
 rtl/seg7_pkg.sv | 24 ++
 rtl/seg7_to_bin_if.sv | 27 ++
 rtl/seg7_decode.sv | 34 +++
 rtl/seg7_to_bin.sv | 126 ++++++++++++
 tb/tb_seg7_to_bin.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions for the display encoder and the
// seg7_to_bin readback/entry converter.
//   SEG_0..SEG_9 : active-low segment codes, bit6 = a .. bit0 = g
//   SEG_BLANK    : all segments off, accepted as a leading zero
//   ST_*         : seg7_to_bin FSM state encodings
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/seg7_to_bin_if.sv
// Handshake bundle for seg7_to_bin.
//   seg_in/in_valid/in_ready             : code input side
//   bin_out/err_*/out_valid/out_ready    : result output side
// master = producer/consumer environment, slave = converter.
interface seg7_to_bin_if #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 8
);
  logic [7*DIGITS-1:0] seg_in;
  logic                in_valid;
  logic                in_ready;
  logic [BIN_W-1:0]    bin_out;
  logic                err_digit;
  logic                err_range;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output seg_in, in_valid, out_ready,
    input  in_ready, bin_out, err_digit, err_range, out_valid
  );

  modport slave (
    input  seg_in, in_valid, out_ready,
    output in_ready, bin_out, err_digit, err_range, out_valid
  );
endinterface

// File: rtl/seg7_decode.sv
// Combinational seven-segment decoder.
//   code     : active-low segment code, bit6 = a .. bit0 = g
//   digit    : decoded value 0..9 (0 when invalid or blank)
//   valid    : code is one of the ten digit codes
//   is_blank : code is the all-off blank pattern (not counted as valid)
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] code,
  output logic [3:0] digit,
  output logic       valid,
  output logic       is_blank
);

  always_comb begin
    digit    = 4'd0;
    valid    = 1'b1;
    is_blank = (code == SEG_BLANK);
    case (code)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_to_bin.sv
// Seven-segment code to binary converter.
// Decodes DIGITS segment codes to BCD, then converts serially by reverse
// double dabble: ACC_W cycles of shift-right with -3 on nibbles >= 8.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : seg7_to_bin_if slave (seg_in/in_valid/in_ready in,
//                bin_out/err_digit/err_range/out_valid/out_ready out)
//
// state   | meaning
// IDLE    | in_ready high, waiting for in_valid
// CONV    | one shift/correct step per cycle, ACC_W steps
// DONE    | result held with out_valid until out_ready
module seg7_to_bin
  import seg7_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 8,
  parameter int ACC_W  = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  seg7_to_bin_if.slave bus
);

  localparam int SH_W  = 4*DIGITS + ACC_W;
  localparam int CNT_W = $clog2(ACC_W + 1);

  logic [1:0]          state;
  logic [4*DIGITS-1:0] bcd_reg;
  logic [ACC_W-1:0]    acc;
  logic [CNT_W-1:0]    cnt;
  logic [BIN_W-1:0]    bin_q;
  logic                err_digit_q;
  logic                err_range_q;
  logic                out_valid_q;

  logic [4*DIGITS-1:0] bcd_dec;
  logic [DIGITS-1:0]   dig_ok;
  logic [SH_W-1:0]     sh;
  logic [ACC_W-1:0]    acc_nxt;
  logic                over;

  for (genvar k = 0; k < DIGITS; k++) begin : g_dec
    logic [3:0] d;
    logic       v;
    logic       blank;
    seg7_decode u_dec (
      .code     (bus.seg_in[7*k +: 7]),
      .digit    (d),
      .valid    (v),
      .is_blank (blank)
    );
    assign bcd_dec[4*k +: 4] = d;
    // A blank reads as a leading zero everywhere except the units digit.
    assign dig_ok[k] = v | (blank & (k != 0));
  end

  always_comb begin
    sh = {bcd_reg, acc} >> 1;
    for (int k = 0; k < DIGITS; k++) begin
      if (sh[ACC_W + 4*k +: 4] >= 4'd8)
        sh[ACC_W + 4*k +: 4] = sh[ACC_W + 4*k +: 4] - 4'd3;
    end
  end

  assign acc_nxt = sh[ACC_W-1:0];
  assign over    = acc_nxt > ACC_W'({BIN_W{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      bcd_reg     <= '0;
      acc         <= '0;
      cnt         <= '0;
      bin_q       <= '0;
      err_digit_q <= 1'b0;
      err_range_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            bcd_reg <= bcd_dec;
            acc     <= '0;
            cnt     <= '0;
            if (!(&dig_ok)) begin
              state       <= ST_DONE;
              bin_q       <= '0;
              err_digit_q <= 1'b1;
              err_range_q <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state <= ST_CONV;
            end
          end
        end
        ST_CONV: begin
          {bcd_reg, acc} <= sh;
          cnt            <= cnt + CNT_W'(1);
          // Result is taken from the final step's value so out_valid
          // rises on the ACC_W-th edge after accept.
          if (cnt == CNT_W'(ACC_W - 1)) begin
            state       <= ST_DONE;
            out_valid_q <= 1'b1;
            err_digit_q <= 1'b0;
            err_range_q <= over;
            bin_q       <= over ? {BIN_W{1'b1}} : acc_nxt[BIN_W-1:0];
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state       <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.bin_out   = bin_q;
  assign bus.err_digit = err_digit_q;
  assign bus.err_range = err_range_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_seg7_to_bin.sv
module tb_seg7_to_bin;

  localparam logic [6:0] C0 = 7'b0000001;
  localparam logic [6:0] C1 = 7'b1001111;
  localparam logic [6:0] C2 = 7'b0010010;
  localparam logic [6:0] C4 = 7'b1001100;
  localparam logic [6:0] C5 = 7'b0100100;
  localparam logic [6:0] C6 = 7'b0100000;
  localparam logic [6:0] C7 = 7'b0001111;
  localparam logic [6:0] C8 = 7'b0000000;
  localparam logic [6:0] C9 = 7'b0000100;
  localparam logic [6:0] CB = 7'b1111111;
  localparam logic [6:0] CX = 7'b1010101;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  seg7_to_bin_if #(.DIGITS(3), .BIN_W(8)) bus ();

  seg7_to_bin dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one job and waits for out_valid; lat = edges after the accept edge.
  task automatic run_job(input logic [20:0] seg, output int lat,
                         output logic [7:0] b, output logic ed, output logic er,
                         output logic to);
    int n;
    to  = 1'b0;
    lat = 0;
    n   = 0;
    b   = '0;
    ed  = 1'b0;
    er  = 1'b0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.in_ready) begin
      to = 1'b1;
      return;
    end
    @(negedge clk);
    bus.seg_in   = seg;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.seg_in   = {3{CX}};
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    if (!bus.out_valid) to = 1'b1;
    b  = bus.bin_out;
    ed = bus.err_digit;
    er = bus.err_range;
  endtask

  task automatic release_out();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.seg_in    = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #3;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.bin_out !== 8'd0) begin failures++; $display("FAIL reset_bin_out got=%0d exp=0", bus.bin_out); end
    checks++; if (bus.err_digit !== 1'b0 || bus.err_range !== 1'b0) begin failures++; $display("FAIL reset_err got=%b%b exp=00", bus.err_digit, bus.err_range); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_max();
    int lat; logic [7:0] b; logic ed, er, to;
    run_job({C2, C5, C5}, lat, b, ed, er, to);
    checks++; if (to) begin failures++; $display("FAIL max_timeout got=timeout exp=out_valid"); end
    checks++; if (lat !== 10) begin failures++; $display("FAIL max_latency got=%0d exp=10", lat); end
    checks++; if (b !== 8'd255) begin failures++; $display("FAIL max_bin got=%0d exp=255", b); end
    checks++; if (ed !== 1'b0 || er !== 1'b0) begin failures++; $display("FAIL max_err got=%b%b exp=00", ed, er); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL max_in_ready_done got=%b exp=0", bus.in_ready); end
    release_out();
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL max_release got=ov%b ir%b exp=ov0 ir1", bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_values();
    logic [20:0] segs [5];
    logic [7:0]  exps [5];
    int lat; logic [7:0] b; logic ed, er, to;
    segs[0] = {CB, CB, C7}; exps[0] = 8'd7;
    segs[1] = {CB, C4, C2}; exps[1] = 8'd42;
    segs[2] = {C0, C0, C0}; exps[2] = 8'd0;
    segs[3] = {C1, C9, C8}; exps[3] = 8'd198;
    segs[4] = {CB, C6, C9}; exps[4] = 8'd69;
    for (int i = 0; i < 5; i++) begin
      run_job(segs[i], lat, b, ed, er, to);
      checks++; if (to || lat !== 10) begin failures++; $display("FAIL value%0d_latency got=%0d to=%b exp=10", i, lat, to); end
      checks++; if (b !== exps[i]) begin failures++; $display("FAIL value%0d_bin got=%0d exp=%0d", i, b, exps[i]); end
      checks++; if (ed !== 1'b0 || er !== 1'b0) begin failures++; $display("FAIL value%0d_err got=%b%b exp=00", i, ed, er); end
      release_out();
    end
  endtask

  task automatic test_range();
    int lat; logic [7:0] b; logic ed, er, to;
    run_job({C9, C9, C9}, lat, b, ed, er, to);
    checks++; if (to || b !== 8'hFF || er !== 1'b1 || ed !== 1'b0) begin failures++; $display("FAIL range_999 got=%0h er=%b ed=%b exp=ff er=1 ed=0", b, er, ed); end
    release_out();
    run_job({C2, C5, C6}, lat, b, ed, er, to);
    checks++; if (to || b !== 8'hFF || er !== 1'b1 || ed !== 1'b0) begin failures++; $display("FAIL range_256 got=%0h er=%b ed=%b exp=ff er=1 ed=0", b, er, ed); end
    checks++; if (lat !== 10) begin failures++; $display("FAIL range_latency got=%0d exp=10", lat); end
    release_out();
  endtask

  task automatic test_digit_err();
    logic [20:0] segs [3];
    int lat; logic [7:0] b; logic ed, er, to;
    segs[0] = {C1, C2, CB};
    segs[1] = {C1, CX, C5};
    segs[2] = {CX, C2, C5};
    for (int i = 0; i < 3; i++) begin
      // Leave a nonzero result behind so a cleared bin_out is meaningful.
      run_job({C2, C5, C5}, lat, b, ed, er, to);
      release_out();
      run_job(segs[i], lat, b, ed, er, to);
      checks++; if (to || lat !== 0) begin failures++; $display("FAIL digit%0d_latency got=%0d to=%b exp=0", i, lat, to); end
      checks++; if (ed !== 1'b1 || er !== 1'b0 || b !== 8'd0) begin failures++; $display("FAIL digit%0d_result got=bin%0d ed%b er%b exp=bin0 ed1 er0", i, b, ed, er); end
      release_out();
    end
  endtask

  task automatic test_hold();
    int lat; logic [7:0] b; logic ed, er, to;
    int bad;
    run_job({C1, C0, C0}, lat, b, ed, er, to);
    checks++; if (to || b !== 8'd100) begin failures++; $display("FAIL hold_first got=%0d exp=100", b); end
    bad = 0;
    @(negedge clk);
    bus.seg_in   = {C2, C0, C0};
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b1 || bus.bin_out !== 8'd100 || bus.in_ready !== 1'b0 ||
          bus.err_digit !== 1'b0 || bus.err_range !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL hold_stable got=%0d_bad_cycles exp=0", bad); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    release_out();
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL hold_release got=ov%b ir%b exp=ov0 ir1", bus.out_valid, bus.in_ready); end
    run_job({C0, C6, C4}, lat, b, ed, er, to);
    checks++; if (to || b !== 8'd64 || lat !== 10) begin failures++; $display("FAIL hold_next got=%0d lat=%0d exp=64 lat=10", b, lat); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [7:0] b; logic ed, er, to;
    int seen;
    // bin_out still holds 64 from the previous job, released here.
    release_out();
    @(negedge clk);
    bus.seg_in   = {C2, C5, C5};
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.bin_out !== 8'd0 || bus.err_digit !== 1'b0 || bus.err_range !== 1'b0) begin failures++; $display("FAIL midreset_outputs got=ov%b bin%0d ed%b er%b exp=all0", bus.out_valid, bus.bin_out, bus.err_digit, bus.err_range); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL midreset_in_ready got=%b exp=1", bus.in_ready); end
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL midreset_no_result got=%0d exp=0", seen); end
    run_job({C1, C2, C8}, lat, b, ed, er, to);
    checks++; if (to || b !== 8'd128 || lat !== 10 || ed !== 1'b0 || er !== 1'b0) begin failures++; $display("FAIL midreset_next got=%0d lat=%0d exp=128 lat=10", b, lat); end
    release_out();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_max();
    test_values();
    test_range();
    test_digit_err();
    test_hold();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
